decode_issue_ctrl: RTL and testbench
====================================

Name: decode_issue_ctrl

Overview:
Decode-stage controller that sequences instructions from fetch into the ID/EX pipeline register. It decodes the opcode into the immediate-format select consumed by the immediate extender, together with register fields and control flags. It runs a valid/ready handshake on both sides, inserts load-use bubbles, and honours branch flushes. It sits between the IF/ID register and the execute stage.

Parameters:
XLEN, 32, instruction/PC width
CNT_W, 16, width of the saturating bubble counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
if_valid  in  1  fetch presents an instruction
if_instr  in  XLEN  instruction word
if_pc  in  XLEN  instruction PC
id_ready  out  1  decode accepts if_instr this cycle
flush  in  1  branch/jump redirect from execute; kill in-flight decode
ex_ready  in  1  execute accepts ex_* this cycle
ex_valid  out  1  ex_* holds a live instruction
ex_instr  out  XLEN  registered instruction word
ex_pc  out  XLEN  registered PC
ex_imm_type  out  3  000 I, 001 S, 010 B, 011 J, 100 U
ex_use_imm  out  1  ALU operand B is the immediate
ex_rd  out  5  destination register
ex_is_load  out  1  opcode 0000011
illegal_instr  out  1  one-cycle pulse on an illegal opcode (see Optional Feature)
bubble_cnt  out  CNT_W  count of load-use bubbles, saturating

Behaviour:
- Reset (async, any time, including mid-handshake): ex_valid=0, all ex_* =0, illegal_instr=0, bubble_cnt=0, state=EMPTY. id_ready=1 in the first cycle after reset deassertion.
- load_en = !ex_valid || ex_ready.
- hazard = if_valid && ex_valid && ex_is_load && ex_rd!=0 && ((uses_rs1 && instr[19:15]==ex_rd) || (uses_rs2 && instr[24:20]==ex_rd)).
- uses_rs1: all opcodes except LUI, AUIPC, JAL. uses_rs2: R (0110011), S, B.
- id_ready = flush || (load_en && !hazard). This is combinational.
- Decode map:
  - 0000011, 0010011, 1100111 -> I, use_imm=1
  - 0100011 -> S, use_imm=1
  - 1100011 -> B, use_imm=0
  - 1101111 -> J, use_imm=1
  - 0110111, 0010111 -> U, use_imm=1
  - 0110011 -> type 000, use_imm=0
  - Any other opcode is illegal.
- Priority per rising edge: flush > hazard > transfer > hold.
  - flush: ex_valid<=0. The if_instr offered this cycle is consumed and discarded.
  - hazard && load_en: ex_valid<=0 (bubble), fetch holds its input, bubble_cnt+=1 (saturates at all-ones), next state=BUBBLE.
  - if_valid && id_ready: the ex_* fields are loaded and ex_valid<=1. Latency is 1 cycle from acceptance to ex_valid.
  - !if_valid && load_en: ex_valid<=0.
  - !load_en: every ex_* output holds stable.
- States:
  - EMPTY (ex_valid=0)
  - FULL (ex_valid=1)
  - BUBBLE (the bubble was issued last cycle). BUBBLE always exits to FULL or EMPTY next cycle and never stalls twice on the same load.
- ex_rd=0 on S/B opcodes. ex_instr and ex_pc are forwarded bit-exact.
- The simultaneous case of flush and hazard resolves as flush: no bubble is counted.

Optional Feature:
ILLEGAL_TRAP_EN.
- Defined: an illegal opcode accepted with if_valid && id_ready pulses illegal_instr for 1 cycle (registered, aligned with where ex_valid would have risen). The instruction is dropped, so ex_valid<=0.
- Undefined: illegal_instr is tied to 0. Illegal opcodes pass through as an I-type with use_imm=0, ex_is_load=0, ex_rd=0 (NOP behaviour).

Test Plan:
1. Opcode sweep, ex_ready=1. Send 0x00A00093 (addi x1,x0,10) -> next cycle ex_valid=1, ex_imm_type=000, ex_use_imm=1, ex_rd=1. Then 0x00112023 (sw) -> 001, ex_rd=0. Then 0x00208463 (beq) -> 010, use_imm=0. Then 0x008000EF (jal) -> 011. Then 0x000012B7 (lui) -> 100.
2. Load-use: lw x5,0(x1) followed by add x6,x5,x2. The cycle after lw is issued: id_ready=0, then ex_valid=0 for 1 cycle, bubble_cnt=1, then add issues. Repeat with rd=x0 -> no bubble.
3. Backpressure: hold ex_ready=0 for 3 cycles while FULL -> id_ready=0 and ex_* unchanged throughout. ex_ready=1 -> next instruction loads the following cycle.
4. Flush: assert flush in the same cycle as if_valid with a load-use hazard pending -> id_ready=1, ex_valid=0 next cycle, bubble_cnt unchanged.
5. Illegal opcode 0x0000007F: with ILLEGAL_TRAP_EN -> illegal_instr=1 for exactly one cycle, ex_valid=0. Without it -> ex_valid=1, imm_type=000, illegal_instr=0.
6. Async reset asserted mid-stall, between clock edges -> ex_valid and bubble_cnt are 0 immediately. After release, id_ready=1 and the first instruction issues 1 cycle after acceptance. Separately, 2^CNT_W+2 forced bubbles -> bubble_cnt saturates at all-ones.

Source files
------------

// File: rtl/decode_issue_ctrl.sv
// Decode/issue controller: decodes fetch instructions into the ID/EX register with load-use bubbles and flush.
// Optional ILLEGAL_TRAP_EN: illegal opcodes are dropped and flagged; otherwise they issue as a NOP-like I-type.
module decode_issue_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [XLEN-1:0]  if_instr,
    input  logic [XLEN-1:0]  if_pc,
    output logic             id_ready,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_instr,
    output logic [XLEN-1:0]  ex_pc,
    output logic [2:0]       ex_imm_type,
    output logic             ex_use_imm,
    output logic [4:0]       ex_rd,
    output logic             ex_is_load,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef enum logic [1:0] {EMPTY, FULL, BUBBLE} state_t;
    state_t state, next_state;

    logic [6:0] opcode;
    logic [2:0] dec_type;
    logic       dec_use_imm;
    logic       dec_rd_en;
    logic       uses_rs1;
    logic       uses_rs2;
    logic [4:0] dec_rd;
    logic       dec_is_load;
    logic       load_en;
    logic       hazard;
    logic       accept;
    logic       drop;
`ifdef ILLEGAL_TRAP_EN
    logic       dec_legal;
`endif

    assign opcode = if_instr[6:0];

    always_comb begin
        dec_type    = IMM_I;
        dec_use_imm = 1'b0;
        dec_rd_en   = 1'b1;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        dec_legal   = 1'b1;
`endif
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: dec_use_imm = 1'b1;
            OP_STORE: begin
                dec_type    = IMM_S;
                dec_use_imm = 1'b1;
                dec_rd_en   = 1'b0;
                uses_rs2    = 1'b1;
            end
            OP_BRANCH: begin
                dec_type  = IMM_B;
                dec_rd_en = 1'b0;
                uses_rs2  = 1'b1;
            end
            OP_JAL: begin
                dec_type    = IMM_J;
                dec_use_imm = 1'b1;
                uses_rs1    = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                dec_type    = IMM_U;
                dec_use_imm = 1'b1;
                uses_rs1    = 1'b0;
            end
            OP_REG: uses_rs2 = 1'b1;
            default: begin
                // Unknown opcodes never write a register, so they cannot trigger a hazard downstream
                dec_rd_en = 1'b0;
`ifdef ILLEGAL_TRAP_EN
                dec_legal = 1'b0;
`endif
            end
        endcase
    end

    assign dec_rd      = dec_rd_en ? if_instr[11:7] : 5'd0;
    assign dec_is_load = (opcode == OP_LOAD);

`ifdef ILLEGAL_TRAP_EN
    assign drop = !dec_legal;
`else
    assign drop = 1'b0;
`endif

    assign load_en  = !ex_valid || ex_ready;
    assign hazard   = if_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                      ((uses_rs1 && (if_instr[19:15] == ex_rd)) ||
                       (uses_rs2 && (if_instr[24:20] == ex_rd)));
    assign id_ready = flush || (load_en && !hazard);
    assign accept   = if_valid && id_ready && !flush;
    assign ex_valid = (state == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (flush)                  next_state = EMPTY;
        else if (hazard && load_en) next_state = BUBBLE;
        else if (accept)            next_state = drop ? EMPTY : FULL;
        else if (load_en)           next_state = EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_instr    <= '0;
            ex_pc       <= '0;
            ex_imm_type <= 3'd0;
            ex_use_imm  <= 1'b0;
            ex_rd       <= 5'd0;
            ex_is_load  <= 1'b0;
        end else if (accept && !drop) begin
            ex_instr    <= if_instr;
            ex_pc       <= if_pc;
            ex_imm_type <= dec_type;
            ex_use_imm  <= dec_use_imm;
            ex_rd       <= dec_rd;
            ex_is_load  <= dec_is_load;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!flush && hazard && load_en && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) illegal_instr <= 1'b0;
        else     illegal_instr <= accept && drop;
    end
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: opcode table plus load-use, backpressure, flush, illegal, reset and saturation sequences.
module tb_decode_issue_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             if_valid;
    logic [XLEN-1:0]  if_instr;
    logic [XLEN-1:0]  if_pc;
    logic             id_ready;
    logic             flush;
    logic             ex_ready;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_instr;
    logic [XLEN-1:0]  ex_pc;
    logic [2:0]       ex_imm_type;
    logic             ex_use_imm;
    logic [4:0]       ex_rd;
    logic             ex_is_load;
    logic             illegal_instr;
    logic [CNT_W-1:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    decode_issue_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_instr(ex_instr), .ex_pc(ex_pc), .ex_imm_type(ex_imm_type), .ex_use_imm(ex_use_imm),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .illegal_instr(illegal_instr), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  typ;
        logic        use_imm;
        logic [4:0]  rd;
        logic        is_load;
    } vec_t;

    localparam logic [31:0] LW_X5   = 32'h0000A283;
    localparam logic [31:0] LW_X0   = 32'h0000A003;
    localparam logic [31:0] ADD_X5  = 32'h00228333;
    localparam logic [31:0] ADD_X0  = 32'h00200333;
    localparam logic [31:0] ADDI    = 32'h00A00093;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        if_instr = instr;
        if_pc    = pc;
        if_valid = 1'b1;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'h00A00093, 32'h1000, 3'b000, 1'b1, 5'd1, 1'b0};
        vecs[1] = '{32'h00112023, 32'h1004, 3'b001, 1'b1, 5'd0, 1'b0};
        vecs[2] = '{32'h00208463, 32'h1008, 3'b010, 1'b0, 5'd0, 1'b0};
        vecs[3] = '{32'h008000EF, 32'h100C, 3'b011, 1'b1, 5'd1, 1'b0};
        vecs[4] = '{32'h000012B7, 32'h1010, 3'b100, 1'b1, 5'd5, 1'b0};
        vecs[5] = '{32'h00228333, 32'h1014, 3'b000, 1'b0, 5'd6, 1'b0};
        vecs[6] = '{32'h000080E7, 32'h1018, 3'b000, 1'b1, 5'd1, 1'b0};
        vecs[7] = '{32'h00000297, 32'h101C, 3'b100, 1'b1, 5'd5, 1'b0};
        vecs[8] = '{32'h0000A283, 32'h1020, 3'b000, 1'b1, 5'd5, 1'b1};

        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0; ex_ready = 1'b1;
        #12 rst = 1'b0;
        #1;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ex_instr", ex_instr, 32'd0);
        chk("rst_bubble", {28'd0, bubble_cnt}, 32'd0);
        chk("rst_illegal", {31'd0, illegal_instr}, 32'd0);
        chk("rst_id_ready", {31'd0, id_ready}, 32'd1);

        // Opcode table, one instruction per cycle with ex_ready high
        tick();
        for (int i = 0; i < 9; i++) begin
            present(vecs[i].instr, vecs[i].pc);
            tick();
            if_valid = 1'b0;
            chk("tbl_valid", {31'd0, ex_valid}, 32'd1);
            chk("tbl_instr", ex_instr, vecs[i].instr);
            chk("tbl_pc", ex_pc, vecs[i].pc);
            chk("tbl_type", {29'd0, ex_imm_type}, {29'd0, vecs[i].typ});
            chk("tbl_use_imm", {31'd0, ex_use_imm}, {31'd0, vecs[i].use_imm});
            chk("tbl_rd", {27'd0, ex_rd}, {27'd0, vecs[i].rd});
            chk("tbl_is_load", {31'd0, ex_is_load}, {31'd0, vecs[i].is_load});
        end

        // Load-use: lw x5 then add reading x5 -> one bubble
        present(LW_X5, 32'h2000);
        tick();
        present(ADD_X5, 32'h2004);
        #1 chk("lu_id_ready_stall", {31'd0, id_ready}, 32'd0);
        tick();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_cnt", {28'd0, bubble_cnt}, 32'd1);
        chk("lu_id_ready_after", {31'd0, id_ready}, 32'd1);
        tick();
        if_valid = 1'b0;
        chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_add_instr", ex_instr, ADD_X5);

        // Load to x0 never stalls
        present(LW_X0, 32'h2008);
        tick();
        present(ADD_X0, 32'h200C);
        #1 chk("x0_id_ready", {31'd0, id_ready}, 32'd1);
        tick();
        if_valid = 1'b0;
        chk("x0_valid", {31'd0, ex_valid}, 32'd1);
        chk("x0_instr", ex_instr, ADD_X0);
        chk("x0_bubble", {28'd0, bubble_cnt}, 32'd1);

        // Backpressure: ex_* hold for three cycles
        ex_ready = 1'b0;
        present(ADDI, 32'h3000);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_id_ready", {31'd0, id_ready}, 32'd0);
            chk("bp_instr", ex_instr, ADD_X0);
            chk("bp_pc", ex_pc, 32'h200C);
            chk("bp_valid", {31'd0, ex_valid}, 32'd1);
            tick();
        end
        ex_ready = 1'b1;
        #1 chk("bp_release_ready", {31'd0, id_ready}, 32'd1);
        tick();
        if_valid = 1'b0;
        chk("bp_load_instr", ex_instr, ADDI);
        chk("bp_load_valid", {31'd0, ex_valid}, 32'd1);

        // Flush coinciding with a pending load-use hazard
        present(LW_X5, 32'h4000);
        tick();
        present(ADD_X5, 32'h4004);
        flush = 1'b1;
        #1 chk("fl_id_ready", {31'd0, id_ready}, 32'd1);
        tick();
        flush = 1'b0;
        if_valid = 1'b0;
        chk("fl_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_bubble", {28'd0, bubble_cnt}, 32'd1);

        // Illegal opcode
        present(32'h0000007F, 32'h5000);
        tick();
        if_valid = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        chk("ill_pulse", {31'd0, illegal_instr}, 32'd1);
        chk("ill_valid", {31'd0, ex_valid}, 32'd0);
        tick();
        chk("ill_pulse_end", {31'd0, illegal_instr}, 32'd0);
`else
        chk("ill_valid", {31'd0, ex_valid}, 32'd1);
        chk("ill_type", {29'd0, ex_imm_type}, 32'd0);
        chk("ill_use_imm", {31'd0, ex_use_imm}, 32'd0);
        chk("ill_is_load", {31'd0, ex_is_load}, 32'd0);
        chk("ill_rd", {27'd0, ex_rd}, 32'd0);
        chk("ill_flag", {31'd0, illegal_instr}, 32'd0);
`endif

        // Async reset asserted mid-stall
        present(LW_X5, 32'h6000);
        tick();
        ex_ready = 1'b0;
        present(ADD_X5, 32'h6004);
        #1 chk("rs_stall", {31'd0, id_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rs_valid", {31'd0, ex_valid}, 32'd0);
        chk("rs_bubble", {28'd0, bubble_cnt}, 32'd0);
        chk("rs_instr", ex_instr, 32'd0);
        #2 rst = 1'b0;
        if_valid = 1'b0;
        ex_ready = 1'b1;
        #1 chk("rs_id_ready", {31'd0, id_ready}, 32'd1);
        present(ADDI, 32'h6008);
        tick();
        if_valid = 1'b0;
        chk("rs_first_valid", {31'd0, ex_valid}, 32'd1);
        chk("rs_first_instr", ex_instr, ADDI);

        // Bubble counter saturation: 2^CNT_W+2 bubbles
        for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
            present(LW_X5, 32'h7000);
            tick();
            present(ADD_X5, 32'h7004);
            tick();
            tick();
            if (i == 13) chk("sat_pre", {28'd0, bubble_cnt}, 32'd14);
        end
        if_valid = 1'b0;
        chk("sat_final", {28'd0, bubble_cnt}, 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
